// File: rtl/state_force_arbiter_if.sv
// Force-request bus between override sources and the arbiter.
// master drives REQ/REQ_VAL/REL/LOAD_EN/DATA_IN; slave returns STATE/GNT/BUSY/TIMEOUT.
interface state_force_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       REQ;
  logic [NREQ*WIDTH-1:0] REQ_VAL;
  logic [NREQ-1:0]       REL;
  logic                  LOAD_EN;
  logic [WIDTH-1:0]      DATA_IN;
  logic [WIDTH-1:0]      STATE;
  logic [NREQ-1:0]       GNT;
  logic                  BUSY;
  logic                  TIMEOUT;

  modport master (
    output REQ, REQ_VAL, REL, LOAD_EN, DATA_IN,
    input  STATE, GNT, BUSY, TIMEOUT
  );

  modport slave (
    input  REQ, REQ_VAL, REL, LOAD_EN, DATA_IN,
    output STATE, GNT, BUSY, TIMEOUT
  );
endinterface

// File: rtl/state_force_arbiter.sv
// Round-robin force arbiter owning a shared state register.
// Ports: CLOCK, RST (async high), bus (slave): REQ/REQ_VAL/REL/LOAD_EN/DATA_IN in, STATE/GNT/BUSY/TIMEOUT out.
module state_force_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 15
) (
  input logic CLOCK,
  input logic RST,
  state_force_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    FORCE,
    RECOVER
  } st_t;

  st_t st_q, st_d;

  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    gidx_q;
  logic [IW-1:0]    pick;
  logic             any_req;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] state_q;
  logic             tmo_q;
  logic             rel_g;
  logic             drop_g;
  logic             expire;
  logic [WIDTH-1:0] pick_val;
  logic [WIDTH-1:0] gnt_val;
  logic [NREQ-1:0]  gnt;
  logic             busy;

  // Descending scan so the lowest offset from the pointer wins.
  always_comb begin : arb
    int idx;
    idx     = 0;
    any_req = 1'b0;
    pick    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.REQ[idx]) begin
        any_req = 1'b1;
        pick    = IW'(idx);
      end
    end
  end

  always_comb begin
    pick_val = bus.REQ_VAL[int'(pick)*WIDTH +: WIDTH];
    gnt_val  = bus.REQ_VAL[int'(gidx_q)*WIDTH +: WIDTH];
    rel_g    = bus.REL[gidx_q];
    drop_g   = !bus.REQ[gidx_q];
    // Counter holds completed FORCE cycles minus one.
    expire   = (int'(cnt_q) + 1) >= HOLD_MAX;
  end

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) st_q <= IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (any_req) st_d = FORCE;
      FORCE:   if (rel_g || drop_g || expire) st_d = RECOVER;
      RECOVER: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      ptr_q   <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      state_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      unique case (1'b1)
        (st_q == IDLE): begin
          if (any_req) begin
            gidx_q  <= pick;
            state_q <= pick_val;
            cnt_q   <= '0;
          end else if (bus.LOAD_EN) begin
            state_q <= bus.DATA_IN;
          end
        end
        (st_q == FORCE): begin
          state_q <= gnt_val;
          // Release or request drop outranks expiry.
          if (rel_g || drop_g) begin
            tmo_q <= 1'b0;
          end else if (expire) begin
            tmo_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        (st_q == RECOVER): begin
          cnt_q <= '0;
          ptr_q <= (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt  = '0;
    busy = 1'b0;
    if (st_q == FORCE) begin
      gnt[gidx_q] = 1'b1;
      busy        = 1'b1;
    end
  end

  assign bus.STATE   = state_q;
  assign bus.GNT     = gnt;
  assign bus.BUSY    = busy;
  assign bus.TIMEOUT = tmo_q;
endmodule

// File: tb/tb_state_force_arbiter.sv
// Self-checking bench for state_force_arbiter.
// Vector table, directed corner sequences and random stimulus vs a reference model.
module tb_state_force_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int HM   = 15;
  localparam logic [31:0] V = 32'h44C3_0011;

  logic CLOCK = 1'b0;
  logic RST   = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  state_force_arbiter_if #(.NREQ(NREQ), .WIDTH(W)) bus ();

  state_force_arbiter #(
    .NREQ(NREQ), .WIDTH(W), .HOLD_MAX(HM)
  ) dut (
    .CLOCK(CLOCK),
    .RST  (RST),
    .bus  (bus.slave)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference model: granted index (-1 = none) and a cooldown flag.
  logic [7:0] m_state;
  int         m_g, m_last, m_ptr, m_held;
  bit         m_cool, m_tmo;

  task automatic model_reset();
    m_state = 8'h00;
    m_g     = -1;
    m_last  = 0;
    m_ptr   = 0;
    m_held  = 0;
    m_cool  = 0;
    m_tmo   = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [31:0] v,
                            input logic [3:0] rl, input logic ld,
                            input logic [7:0] d);
    int found;
    m_tmo = 0;
    if (m_cool) begin
      m_cool = 0;
      m_ptr  = (m_last + 1) % NREQ;
    end else if (m_g < 0) begin
      found = -1;
      for (int k = 0; k < NREQ; k++)
        if (found < 0 && r[(m_ptr + k) % NREQ]) found = (m_ptr + k) % NREQ;
      if (found >= 0) begin
        m_g     = found;
        m_held  = 1;
        m_state = v[found*8 +: 8];
      end else if (ld) begin
        m_state = d;
      end
    end else begin
      m_state = v[m_g*8 +: 8];
      if (rl[m_g] || !r[m_g]) begin
        m_last = m_g;
        m_g    = -1;
        m_cool = 1;
      end else if (m_held == HM) begin
        m_last = m_g;
        m_g    = -1;
        m_cool = 1;
        m_tmo  = 1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle, advance the model, then compare after the edge.
  task automatic cycle(input logic [3:0] r, input logic [31:0] v,
                       input logic [3:0] rl, input logic ld,
                       input logic [7:0] d);
    logic [3:0] eg;
    bus.REQ     = r;
    bus.REQ_VAL = v;
    bus.REL     = rl;
    bus.LOAD_EN = ld;
    bus.DATA_IN = d;
    model_step(r, v, rl, ld, d);
    @(posedge CLOCK);
    #1;
    eg = (m_g < 0) ? 4'b0000 : 4'(1 << m_g);
    chk("m_state", 32'(bus.STATE), 32'(m_state));
    chk("m_gnt", 32'(bus.GNT), 32'(eg));
    chk("m_busy", 32'(bus.BUSY), 32'(m_g >= 0));
    chk("m_tmo", 32'(bus.TIMEOUT), 32'(m_tmo));
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] rel;
    logic       ld;
    logic [7:0] din;
    logic [7:0] e_state;
    logic [3:0] e_gnt;
    logic       e_busy;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int         hi;
    logic [3:0] rq;
    logic [3:0] rl;
    logic [31:0] val;

    tbl[0]  = '{4'b0000, 4'b0000, 1'b1, 8'h5A, 8'h5A, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0010, 4'b0000, 1'b1, 8'hFF, 8'h00, 4'b0010, 1'b1};
    tbl[2]  = '{4'b0010, 4'b0000, 1'b1, 8'hFF, 8'h00, 4'b0010, 1'b1};
    tbl[3]  = '{4'b0010, 4'b0010, 1'b1, 8'hFF, 8'h00, 4'b0000, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b1, 8'hFF, 8'h00, 4'b0000, 1'b0};
    tbl[5]  = '{4'b0000, 4'b0000, 1'b0, 8'hFF, 8'h00, 4'b0000, 1'b0};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b1, 8'h33, 8'h33, 4'b0000, 1'b0};
    tbl[7]  = '{4'b1111, 4'b0000, 1'b0, 8'h00, 8'hC3, 4'b0100, 1'b1};
    tbl[8]  = '{4'b1111, 4'b0000, 1'b0, 8'h00, 8'hC3, 4'b0100, 1'b1};
    tbl[9]  = '{4'b1111, 4'b0100, 1'b0, 8'h00, 8'hC3, 4'b0000, 1'b0};
    tbl[10] = '{4'b1111, 4'b0000, 1'b0, 8'h00, 8'hC3, 4'b0000, 1'b0};
    tbl[11] = '{4'b1111, 4'b0000, 1'b1, 8'h77, 8'h44, 4'b1000, 1'b1};
    tbl[12] = '{4'b1111, 4'b1000, 1'b0, 8'h00, 8'h44, 4'b0000, 1'b0};
    tbl[13] = '{4'b1111, 4'b0000, 1'b0, 8'h00, 8'h44, 4'b0000, 1'b0};
    tbl[14] = '{4'b1111, 4'b0000, 1'b0, 8'h00, 8'h11, 4'b0001, 1'b1};
    tbl[15] = '{4'b1111, 4'b0010, 1'b0, 8'h00, 8'h11, 4'b0001, 1'b1};
    tbl[16] = '{4'b1110, 4'b0000, 1'b0, 8'h00, 8'h11, 4'b0000, 1'b0};
    tbl[17] = '{4'b0000, 4'b0000, 1'b0, 8'h00, 8'h11, 4'b0000, 1'b0};
    tbl[18] = '{4'b0000, 4'b0000, 1'b1, 8'h9C, 8'h9C, 4'b0000, 1'b0};

    bus.REQ     = '0;
    bus.REQ_VAL = '0;
    bus.REL     = '0;
    bus.LOAD_EN = 1'b0;
    bus.DATA_IN = '0;
    model_reset();
    repeat (2) @(posedge CLOCK);
    #1;
    chk("rst_state", 32'(bus.STATE), 32'h0);
    chk("rst_gnt", 32'(bus.GNT), 32'h0);
    chk("rst_busy", 32'(bus.BUSY), 32'h0);
    chk("rst_tmo", 32'(bus.TIMEOUT), 32'h0);
    @(negedge CLOCK);
    RST = 1'b0;
    @(posedge CLOCK);
    #1;

    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].req, V, tbl[i].rel, tbl[i].ld, tbl[i].din);
      chk($sformatf("vec%0d_state", i), 32'(bus.STATE), 32'(tbl[i].e_state));
      chk($sformatf("vec%0d_gnt", i), 32'(bus.GNT), 32'(tbl[i].e_gnt));
      chk($sformatf("vec%0d_busy", i), 32'(bus.BUSY), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d_tmo", i), 32'(bus.TIMEOUT), 32'h0);
    end

    // Timeout on requester 2, then requester 3 wins the next grant.
    cycle(4'b0100, V, 4'b0000, 1'b0, 8'h00);
    chk("to_grant", 32'(bus.GNT), 32'b0100);
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      cycle(4'b0100, V, 4'b0000, 1'b0, 8'h00);
      if (bus.GNT != 4'b0100) break;
      hi++;
    end
    chk("to_hold_cycles", 32'(hi), 32'(HM));
    chk("to_pulse", 32'(bus.TIMEOUT), 32'h1);
    chk("to_gnt_drop", 32'(bus.GNT), 32'h0);
    cycle(4'b1100, V, 4'b0000, 1'b0, 8'h00);
    chk("to_pulse_end", 32'(bus.TIMEOUT), 32'h0);
    cycle(4'b1100, V, 4'b0000, 1'b0, 8'h00);
    chk("to_next_req3", 32'(bus.GNT), 32'b1000);
    cycle(4'b0100, V, 4'b1000, 1'b0, 8'h00);
    cycle(4'b0100, V, 4'b0000, 1'b0, 8'h00);
    cycle(4'b0100, V, 4'b0000, 1'b0, 8'h00);
    chk("to_regrant2", 32'(bus.GNT), 32'b0100);

    // Move the pointer off zero, then reset asynchronously mid-grant.
    cycle(4'b0010, V, 4'b0100, 1'b0, 8'h00);
    cycle(4'b0010, V, 4'b0000, 1'b0, 8'h00);
    cycle(4'b0010, V, 4'b0000, 1'b0, 8'h00);
    cycle(4'b0100, V, 4'b0010, 1'b0, 8'h00);
    cycle(4'b0100, V, 4'b0000, 1'b0, 8'h00);
    cycle(4'b0100, V, 4'b0000, 1'b0, 8'h00);
    chk("ar_pre_gnt", 32'(bus.GNT), 32'b0100);
    #2;
    bus.REQ = 4'b0000;
    RST     = 1'b1;
    #1;
    chk("ar_state", 32'(bus.STATE), 32'h0);
    chk("ar_gnt", 32'(bus.GNT), 32'h0);
    chk("ar_busy", 32'(bus.BUSY), 32'h0);
    model_reset();
    @(negedge CLOCK);
    RST = 1'b0;
    cycle(4'b0110, V, 4'b0000, 1'b0, 8'h00);
    chk("ar_ptr_zero", 32'(bus.GNT), 32'b0010);

    // Value tracking, then release on the expiry edge.
    cycle(4'b0110, V, 4'b0010, 1'b0, 8'h00);
    cycle(4'b0000, V, 4'b0000, 1'b0, 8'h00);
    cycle(4'b0001, 32'h0000_0011, 4'b0000, 1'b0, 8'h00);
    chk("trk_first", 32'(bus.STATE), 32'h11);
    cycle(4'b0001, 32'h0000_0022, 4'b0000, 1'b0, 8'h00);
    chk("trk_change", 32'(bus.STATE), 32'h22);
    for (int i = 0; i < HM - 2; i++)
      cycle(4'b0001, 32'h0000_0022, 4'b0000, 1'b0, 8'h00);
    chk("race_pre_gnt", 32'(bus.GNT), 32'b0001);
    cycle(4'b0001, 32'h0000_0022, 4'b0001, 1'b0, 8'h00);
    chk("race_tmo", 32'(bus.TIMEOUT), 32'h0);
    chk("race_gnt", 32'(bus.GNT), 32'h0);
    chk("race_state", 32'(bus.STATE), 32'h22);

    // Random phase: slowly varying requests, sparse release pulses.
    rq = 4'b0000;
    for (int n = 0; n < 2000; n++) begin
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 9) == 0) rq[b] = ~rq[b];
      rl = '0;
      for (int b = 0; b < NREQ; b++)
        rl[b] = ($urandom_range(0, 19) == 0);
      val = $urandom;
      cycle(rq, val, rl, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
